// File: rtl/score4_game_ctrl.sv
// score4_game_ctrl: Connect Four board, cursor, turn and win/draw sequencing for the VGA plotter.
// Define SCORE4_WIN_DETECT_EN to compile in the four-direction line check and the WIN state.
module score4_game_ctrl #(
    parameter int unsigned START_COL = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_left,
    input  logic                 btn_right,
    input  logic                 btn_drop,
    output logic [6:0][5:0][1:0] panel,
    output logic [6:0]           play,
    output logic                 turn,
    output logic                 busy,
    output logic                 game_over,
    output logic [1:0]           winner
);
    localparam int unsigned N_COL = 7;
    localparam int unsigned N_ROW = 6;
    localparam int unsigned COL_W = 3;
    localparam int unsigned ROW_W = 3;
    localparam int unsigned CNT_W = 6;
    localparam logic [CNT_W-1:0] N_CELLS  = CNT_W'(N_COL * N_ROW);
    localparam logic [COL_W-1:0] COL_MAX  = COL_W'(N_COL - 1);
    localparam logic [COL_W-1:0] COL_INIT = COL_W'(START_COL);
    localparam logic [6:0]       PLAY_INIT = 7'(7'd1 << START_COL);

    typedef enum logic [1:0] { IDLE, CHECK, WIN, DRAW } state_t;

    state_t               state, state_n;
    logic [2:0]           btn_cur, btn_prev;
    logic [2:0]           press;
    logic                 left_p, right_p, drop_p;
    logic [COL_W-1:0]     col, col_n;
    logic [CNT_W-1:0]     move_cnt, move_cnt_n;
    logic [6:0][5:0][1:0] panel_n;
    logic [6:0]           play_n;
    logic                 turn_n, busy_n, game_over_n;
    logic [1:0]           winner_n;
    logic [1:0]           placed;
    logic                 col_free;
    logic [ROW_W-1:0]     tgt_row;

    // Press pulses: one per rising edge of the registered level, so a held button acts once.
    assign press   = btn_cur & ~btn_prev;
    assign left_p  = press[0];
    assign right_p = press[1];
    assign drop_p  = press[2];
    assign placed  = {turn, ~turn};

    // Lowest free cell (largest row index) in the selected column.
    always_comb begin
        col_free = 1'b0;
        tgt_row  = '0;
        for (int r = 0; r < int'(N_ROW); r++) begin
            if (panel[col][ROW_W'(r)] == 2'b00) begin
                col_free = 1'b1;
                tgt_row  = ROW_W'(r);
            end
        end
    end

`ifdef SCORE4_WIN_DETECT_EN
    logic [1:0]       dir, dir_n;
    logic             win_flag, win_flag_n, line_win;
    logic [COL_W-1:0] last_col, last_col_n;
    logic [ROW_W-1:0] last_row, last_row_n;

    // Contiguous run through the last move along the direction selected by dir.
    always_comb begin
        int   dc, dr, c, r, run;
        logic go_f, go_b;
        dc   = 1;
        dr   = 0;
        c    = 0;
        r    = 0;
        run  = 1;
        go_f = 1'b1;
        go_b = 1'b1;
        case (dir)
            2'd0:    begin dc = 1; dr = 0;  end
            2'd1:    begin dc = 0; dr = 1;  end
            2'd2:    begin dc = 1; dr = 1;  end
            default: begin dc = 1; dr = -1; end
        endcase
        for (int k = 1; k <= 3; k++) begin
            c = int'(last_col) + k * dc;
            r = int'(last_row) + k * dr;
            if (go_f && c >= 0 && c < int'(N_COL) && r >= 0 && r < int'(N_ROW)) begin
                if (panel[COL_W'(c)][ROW_W'(r)] == placed) run = run + 1;
                else go_f = 1'b0;
            end else begin
                go_f = 1'b0;
            end
            c = int'(last_col) - k * dc;
            r = int'(last_row) - k * dr;
            if (go_b && c >= 0 && c < int'(N_COL) && r >= 0 && r < int'(N_ROW)) begin
                if (panel[COL_W'(c)][ROW_W'(r)] == placed) run = run + 1;
                else go_b = 1'b0;
            end else begin
                go_b = 1'b0;
            end
        end
        line_win = (run >= 4);
    end
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_n    = state;
        panel_n    = panel;
        col_n      = col;
        move_cnt_n = move_cnt;
        turn_n     = turn;
        winner_n   = winner;
`ifdef SCORE4_WIN_DETECT_EN
        dir_n      = dir;
        win_flag_n = win_flag;
        last_col_n = last_col;
        last_row_n = last_row;
`endif
        case (state)
            IDLE: begin
                if (drop_p) begin
                    if (col_free) begin
                        panel_n[col][tgt_row] = placed;
                        move_cnt_n = move_cnt + CNT_W'(1);
                        state_n    = CHECK;
`ifdef SCORE4_WIN_DETECT_EN
                        last_col_n = col;
                        last_row_n = tgt_row;
                        dir_n      = 2'd0;
                        win_flag_n = 1'b0;
`endif
                    end
                end else if (left_p && !right_p) begin
                    if (col != '0) col_n = col - COL_W'(1);
                end else if (right_p && !left_p) begin
                    if (col != COL_MAX) col_n = col + COL_W'(1);
                end
            end
            CHECK: begin
`ifdef SCORE4_WIN_DETECT_EN
                win_flag_n = win_flag | line_win;
                dir_n      = dir + 2'd1;
                if (dir == 2'd3) begin
                    if (win_flag_n) begin
                        state_n  = WIN;
                        winner_n = placed;
                    end else if (move_cnt == N_CELLS) begin
                        state_n = DRAW;
                    end else begin
                        turn_n  = ~turn;
                        state_n = IDLE;
                    end
                end
`else
                if (move_cnt == N_CELLS) begin
                    state_n = DRAW;
                end else begin
                    turn_n  = ~turn;
                    state_n = IDLE;
                end
`endif
            end
            WIN, DRAW: begin
                if (drop_p) begin
                    panel_n    = '0;
                    turn_n     = 1'b0;
                    col_n      = COL_INIT;
                    move_cnt_n = '0;
                    winner_n   = 2'b00;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n      = (state_n == CHECK);
        game_over_n = (state_n == WIN) || (state_n == DRAW);
        play_n      = 7'(7'd1 << col_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            btn_cur   <= '0;
            btn_prev  <= '0;
            panel     <= '0;
            col       <= COL_INIT;
            play      <= PLAY_INIT;
            move_cnt  <= '0;
            turn      <= 1'b0;
            busy      <= 1'b0;
            game_over <= 1'b0;
            winner    <= 2'b00;
`ifdef SCORE4_WIN_DETECT_EN
            dir       <= 2'd0;
            win_flag  <= 1'b0;
            last_col  <= '0;
            last_row  <= '0;
`endif
        end else begin
            state     <= state_n;
            btn_cur   <= {btn_drop, btn_right, btn_left};
            btn_prev  <= btn_cur;
            panel     <= panel_n;
            col       <= col_n;
            play      <= play_n;
            move_cnt  <= move_cnt_n;
            turn      <= turn_n;
            busy      <= busy_n;
            game_over <= game_over_n;
            winner    <= winner_n;
`ifdef SCORE4_WIN_DETECT_EN
            dir       <= dir_n;
            win_flag  <= win_flag_n;
            last_col  <= last_col_n;
            last_row  <= last_row_n;
`endif
        end
    end

endmodule

// File: tb/tb_score4_game_ctrl.sv
// Bench for score4_game_ctrl: scripted and random play compared against a board-level game model.
// Win expectations follow SCORE4_WIN_DETECT_EN exactly as the design build does.
`timescale 1ns/1ps
module tb_score4_game_ctrl;
`ifdef SCORE4_WIN_DETECT_EN
    localparam bit WIN_EN   = 1'b1;
    localparam int BUSY_LEN = 4;
`else
    localparam bit WIN_EN   = 1'b0;
    localparam int BUSY_LEN = 1;
`endif

    logic clk = 1'b0;
    logic rst, btn_left, btn_right, btn_drop;
    logic [6:0][5:0][1:0] panel;
    logic [6:0] play;
    logic turn, busy, game_over;
    logic [1:0] winner;

    int n_checks = 0;
    int n_pass   = 0;

    // Game model: board[col][row], row 0 on top; codes 0 empty, 1 red, 2 green.
    int board [7][6];
    int m_col, m_turn, m_over, m_winner, m_count;

    score4_game_ctrl #(.START_COL(3)) dut (
        .clk(clk), .rst(rst), .btn_left(btn_left), .btn_right(btn_right), .btn_drop(btn_drop),
        .panel(panel), .play(play), .turn(turn), .busy(busy), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 6; r++) board[c][r] = 0;
        m_col = 3; m_turn = 0; m_over = 0; m_winner = 0; m_count = 0;
    endfunction

    function automatic bit model_has_win(input int code);
        int dcs [4];
        int drs [4];
        dcs = '{1, 0, 1, 1};
        drs = '{0, 1, 1, -1};
        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 6; r++)
                for (int d = 0; d < 4; d++) begin
                    bit ok = 1'b1;
                    for (int k = 0; k < 4; k++) begin
                        int cc = c + k * dcs[d];
                        int rr = r + k * drs[d];
                        if (cc < 0 || cc > 6 || rr < 0 || rr > 5) ok = 1'b0;
                        else if (board[cc][rr] != code) ok = 1'b0;
                    end
                    if (ok) return 1'b1;
                end
        return 1'b0;
    endfunction

    function automatic bit model_drop();
        int row = -1;
        int code;
        if (m_over != 0) begin
            model_reset();
            return 1'b0;
        end
        for (int r = 0; r < 6; r++) if (board[m_col][r] == 0) row = r;
        if (row < 0) return 1'b0;
        code = (m_turn != 0) ? 2 : 1;
        board[m_col][row] = code;
        m_count++;
        if (WIN_EN && model_has_win(code)) begin
            m_over = 1; m_winner = code;
        end else if (m_count == 42) begin
            m_over = 2;
        end else begin
            m_turn = 1 - m_turn;
        end
        return 1'b1;
    endfunction

    function automatic void model_move(input bit l, input bit r);
        if (m_over != 0) return;
        if (l && !r && m_col > 0) m_col--;
        if (r && !l && m_col < 6) m_col++;
    endfunction

    function automatic logic [6:0][5:0][1:0] exp_panel();
        logic [6:0][5:0][1:0] v;
        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 6; r++) v[c][r] = 2'(board[c][r]);
        return v;
    endfunction

    function automatic logic [6:0] exp_play();
        return 7'(1 << m_col);
    endfunction

    task automatic apply_reset();
        rst = 1'b1; btn_left = 1'b0; btn_right = 1'b0; btn_drop = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic pulse(input bit l, input bit r, input bit d);
        @(negedge clk);
        btn_left = l; btn_right = r; btn_drop = d;
        @(negedge clk);
        btn_left = 1'b0; btn_right = 1'b0; btn_drop = 1'b0;
    endtask

    task automatic move(input bit l, input bit r);
        pulse(l, r, 1'b0);
        model_move(l, r);
        @(posedge clk); #1;
    endtask

    // Drop pulse; returns busy-high cycle count (bounded), model acceptance and panel at edge D.
    task automatic drop(output int nbusy, output bit placed, output logic [6:0][5:0][1:0] pd);
        pulse(1'b0, 1'b0, 1'b1);
        placed = model_drop();
        @(posedge clk); #1;
        pd = panel;
        nbusy = 0;
        while (busy === 1'b1 && nbusy < 20) begin
            @(posedge clk); #1;
            nbusy++;
        end
    endtask

    task automatic goto_col(input int c);
        for (int i = 0; i < 8 && m_col != c; i++) begin
            if (m_col > c) move(1'b1, 1'b0);
            else move(1'b0, 1'b1);
        end
    endtask

    task automatic test_reset();
        logic [6:0][5:0][1:0] pd;
        int nb; bit pl;
        apply_reset();
        n_checks++; if (panel !== '0) $display("FAIL reset_panel got=%h exp=0", panel); else n_pass++;
        n_checks++; if (play !== 7'b0001000) $display("FAIL reset_play got=%b exp=0001000", play); else n_pass++;
        n_checks++; if (turn !== 1'b0) $display("FAIL reset_turn got=%b exp=0", turn); else n_pass++;
        n_checks++; if (game_over !== 1'b0) $display("FAIL reset_game_over got=%b exp=0", game_over); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (winner !== 2'b00) $display("FAIL reset_winner got=%b exp=00", winner); else n_pass++;
        // Reset while the drop is still in flight.
        pulse(1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b1) $display("FAIL midreset_busy_at_d got=%b exp=1", busy); else n_pass++;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_reset();
        n_checks++; if (panel !== '0) $display("FAIL midreset_panel got=%h exp=0", panel); else n_pass++;
        n_checks++; if (busy !== 1'b0 || turn !== 1'b0) $display("FAIL midreset_busy_turn got=%b%b exp=00", busy, turn); else n_pass++;
        drop(nb, pl, pd);
        n_checks++; if (pd[3][5] !== 2'b01) $display("FAIL midreset_redrop got=%b exp=01", pd[3][5]); else n_pass++;
    endtask

    task automatic test_cursor();
        apply_reset();
        for (int i = 0; i < 5; i++) move(1'b1, 1'b0);
        n_checks++; if (play !== 7'b0000001) $display("FAIL cursor_left_sat got=%b exp=0000001", play); else n_pass++;
        for (int i = 0; i < 8; i++) move(1'b0, 1'b1);
        n_checks++; if (play !== 7'b1000000) $display("FAIL cursor_right_sat got=%b exp=1000000", play); else n_pass++;
        move(1'b1, 1'b1);
        n_checks++; if (play !== 7'b1000000) $display("FAIL cursor_both got=%b exp=1000000", play); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            int a = $urandom_range(0, 2);
            move(a != 1, a != 0);
            n_checks++; if (play !== exp_play()) $display("FAIL cursor_rand step=%0d got=%b exp=%b", i, play, exp_play()); else n_pass++;
        end
    endtask

    task automatic test_stacking();
        logic [6:0][5:0][1:0] pd;
        int nb; bit pl;
        apply_reset();
        drop(nb, pl, pd);
        n_checks++; if (pd[3][5] !== 2'b01) $display("FAIL stack_first_cell got=%b exp=01", pd[3][5]); else n_pass++;
        n_checks++; if (nb !== BUSY_LEN) $display("FAIL stack_first_busy got=%0d exp=%0d", nb, BUSY_LEN); else n_pass++;
        n_checks++; if (turn !== 1'b1) $display("FAIL stack_first_turn got=%b exp=1", turn); else n_pass++;
        drop(nb, pl, pd);
        n_checks++; if (pd[3][4] !== 2'b10) $display("FAIL stack_second_cell got=%b exp=10", pd[3][4]); else n_pass++;
        n_checks++; if (nb !== BUSY_LEN) $display("FAIL stack_second_busy got=%0d exp=%0d", nb, BUSY_LEN); else n_pass++;
        n_checks++; if (turn !== 1'b0) $display("FAIL stack_second_turn got=%b exp=0", turn); else n_pass++;
        n_checks++; if (panel !== exp_panel()) $display("FAIL stack_panel got=%h exp=%h", panel, exp_panel()); else n_pass++;
    endtask

    task automatic test_full_column();
        logic [6:0][5:0][1:0] pd;
        int nb; bit pl;
        int t_before;
        apply_reset();
        goto_col(0);
        for (int i = 0; i < 6; i++) begin
            drop(nb, pl, pd);
            n_checks++; if (nb !== BUSY_LEN) $display("FAIL full_fill_busy drop=%0d got=%0d exp=%0d", i, nb, BUSY_LEN); else n_pass++;
        end
        t_before = m_turn;
        drop(nb, pl, pd);
        n_checks++; if (nb !== 0) $display("FAIL full_ignored_busy got=%0d exp=0", nb); else n_pass++;
        n_checks++; if (panel !== exp_panel()) $display("FAIL full_panel got=%h exp=%h", panel, exp_panel()); else n_pass++;
        n_checks++; if (turn !== 1'(t_before)) $display("FAIL full_turn got=%b exp=%0d", turn, t_before); else n_pass++;
    endtask

    task automatic test_vertical_win();
        logic [6:0][5:0][1:0] pd;
        int nb; bit pl;
        int seq [7];
        seq = '{0, 1, 0, 1, 0, 1, 0};
        apply_reset();
        foreach (seq[i]) begin
            goto_col(seq[i]);
            drop(nb, pl, pd);
            n_checks++; if (nb !== (pl ? BUSY_LEN : 0)) $display("FAIL vert_busy drop=%0d got=%0d exp=%0d", i, nb, pl ? BUSY_LEN : 0); else n_pass++;
        end
        n_checks++; if (game_over !== 1'(m_over != 0)) $display("FAIL vert_game_over got=%b exp=%0d", game_over, m_over != 0); else n_pass++;
        n_checks++; if (winner !== 2'(m_winner)) $display("FAIL vert_winner got=%b exp=%0d", winner, m_winner); else n_pass++;
        move(1'b1, 1'b0);
        n_checks++; if (play !== exp_play()) $display("FAIL vert_left_after got=%b exp=%b", play, exp_play()); else n_pass++;
        drop(nb, pl, pd);
        n_checks++; if (panel !== exp_panel()) $display("FAIL vert_restart_panel got=%h exp=%h", panel, exp_panel()); else n_pass++;
        n_checks++; if (turn !== 1'(m_turn) || game_over !== 1'(m_over != 0)) $display("FAIL vert_restart_turn got=%b%b exp=%0d%0d", turn, game_over, m_turn, m_over != 0); else n_pass++;
    endtask

    task automatic test_anti_diag();
        logic [6:0][5:0][1:0] pd;
        int nb; bit pl;
        int seq [12];
        seq = '{3, 2, 4, 4, 5, 5, 5, 4, 0, 5, 1, 3};
        apply_reset();
        foreach (seq[i]) begin
            goto_col(seq[i]);
            drop(nb, pl, pd);
        end
        n_checks++; if (winner !== (WIN_EN ? 2'b10 : 2'b00)) $display("FAIL anti_winner got=%b exp=%b", winner, WIN_EN ? 2'b10 : 2'b00); else n_pass++;
        n_checks++; if (game_over !== WIN_EN) $display("FAIL anti_game_over got=%b exp=%b", game_over, WIN_EN); else n_pass++;
        n_checks++; if (panel !== exp_panel()) $display("FAIL anti_panel got=%h exp=%h", panel, exp_panel()); else n_pass++;
    endtask

    task automatic test_draw();
        logic [6:0][5:0][1:0] pd;
        int nb; bit pl;
        int seq [$];
        for (int i = 0; i < 6; i++) seq.push_back(0);
        for (int i = 0; i < 6; i++) seq.push_back(1);
        seq.push_back(4);
        for (int i = 0; i < 6; i++) seq.push_back(2);
        for (int i = 0; i < 5; i++) seq.push_back(4);
        seq.push_back(5);
        for (int i = 0; i < 6; i++) seq.push_back(3);
        for (int i = 0; i < 6; i++) seq.push_back(6);
        for (int i = 0; i < 5; i++) seq.push_back(5);
        apply_reset();
        foreach (seq[i]) begin
            goto_col(seq[i]);
            drop(nb, pl, pd);
            n_checks++; if (nb !== BUSY_LEN) $display("FAIL draw_busy move=%0d got=%0d exp=%0d", i, nb, BUSY_LEN); else n_pass++;
        end
        n_checks++; if (game_over !== 1'b1) $display("FAIL draw_game_over got=%b exp=1", game_over); else n_pass++;
        n_checks++; if (winner !== 2'b00) $display("FAIL draw_winner got=%b exp=00", winner); else n_pass++;
        drop(nb, pl, pd);
        n_checks++; if (panel !== '0 || game_over !== 1'b0 || play !== 7'b0001000) $display("FAIL draw_restart got=%h/%b/%b exp=0/0/0001000", panel, game_over, play); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit pl;
        apply_reset();
        // Second pulse sampled at D+3: still checking unless the line check is compiled out.
        pulse(1'b0, 1'b0, 1'b1);
        pl = model_drop();
        @(posedge clk); #1;
        repeat (3) @(negedge clk);
        btn_drop = 1'b1;
        @(negedge clk);
        btn_drop = 1'b0;
        if (!WIN_EN) pl = model_drop();
        @(posedge clk); #1;
        n_checks++; if (busy !== !WIN_EN) $display("FAIL b2b_d3_busy got=%b exp=%b", busy, !WIN_EN); else n_pass++;
        repeat (6) @(posedge clk); #1;
        n_checks++; if (panel !== exp_panel()) $display("FAIL b2b_d3_panel got=%h exp=%h", panel, exp_panel()); else n_pass++;
        // Pulse sampled at D+4 is the earliest accepted one.
        pulse(1'b0, 1'b0, 1'b1);
        pl = model_drop();
        @(posedge clk); #1;
        repeat (4) @(negedge clk);
        btn_drop = 1'b1;
        @(negedge clk);
        btn_drop = 1'b0;
        pl = model_drop();
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b1) $display("FAIL b2b_d4_busy got=%b exp=1", busy); else n_pass++;
        n_checks++; if (panel !== exp_panel()) $display("FAIL b2b_d4_panel got=%h exp=%h", panel, exp_panel()); else n_pass++;
    endtask

    task automatic test_random();
        logic [6:0][5:0][1:0] pd;
        int nb; bit pl;
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            int a = $urandom_range(0, 5);
            if (a >= 3) begin
                drop(nb, pl, pd);
                n_checks++; if (nb !== (pl ? BUSY_LEN : 0)) $display("FAIL rand_busy step=%0d got=%0d exp=%0d", i, nb, pl ? BUSY_LEN : 0); else n_pass++;
            end else begin
                move(a != 1, a != 0);
            end
            n_checks++; if (panel !== exp_panel()) $display("FAIL rand_panel step=%0d got=%h exp=%h", i, panel, exp_panel()); else n_pass++;
            n_checks++; if (play !== exp_play()) $display("FAIL rand_play step=%0d got=%b exp=%b", i, play, exp_play()); else n_pass++;
            n_checks++; if (turn !== 1'(m_turn)) $display("FAIL rand_turn step=%0d got=%b exp=%0d", i, turn, m_turn); else n_pass++;
            n_checks++; if (game_over !== 1'(m_over != 0) || winner !== 2'(m_winner)) $display("FAIL rand_result step=%0d got=%b/%b exp=%0d/%0d", i, game_over, winner, m_over != 0, m_winner); else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; btn_left = 1'b0; btn_right = 1'b0; btn_drop = 1'b0;
        model_reset();
        test_reset();
        test_cursor();
        test_stacking();
        test_full_column();
        test_vertical_win();
        test_anti_diag();
        test_draw();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
